// File: rtl/fifo_packet_framer_pkg.sv
// Shared definitions for the packet framer and the host-side frame decoder:
// state encoding and the default frame sync byte.
package fifo_packet_framer_pkg;

   // Framer states. SYNC is a reserved encoding that the framer never enters
   // (the sync byte is loaded directly on the IDLE exit).
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      SEQ     = 3'd2,
      PAYLOAD = 3'd3,
      CHK     = 3'd4
   } state_t;

   // First byte of every frame unless overridden.
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/fifo_packet_framer_if.sv
// Bundle of the framer's FIFO read port, tx byte stream and status signals.
// Handshakes: fifo_pop consumes the FWFT head word in the cycle it is high and
// is only raised while fifo_nempty=1; a tx byte transfers in every cycle where
// tx_valid && tx_ready, and tx_data is held stable while tx_valid && !tx_ready.
interface fifo_packet_framer_if #(
   parameter int WIDTH = 8
);
   import fifo_packet_framer_pkg::*;

   logic             fifo_nempty;
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_pop;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             busy;
   logic [WIDTH-1:0] seq;
   state_t           state;      // debug view of the framer FSM

   // Framer side.
   modport master (
      input  fifo_nempty, fifo_data, tx_ready,
      output fifo_pop, tx_data, tx_valid, busy, seq, state
   );

   // Environment side (FIFO and host-link transmitter).
   modport slave (
      output fifo_nempty, fifo_data, tx_ready,
      input  fifo_pop, tx_data, tx_valid, busy, seq, state
   );

endinterface

// File: rtl/fifo_packet_framer.sv
// Packet framer: pops payload bytes from a FWFT FIFO and emits frames
// SYNC, seq, payload[PAYLOAD_LEN], chk as a registered valid/ready stream.
// The checksum makes seq + sum(payload) + chk == 0 modulo 2^WIDTH.
module fifo_packet_framer
   import fifo_packet_framer_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               PAYLOAD_LEN = 16,
   parameter logic [WIDTH-1:0] SYNC_BYTE   = WIDTH'(DEFAULT_SYNC_BYTE)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fifo_packet_framer_if.master bus
);

   localparam int CNT_W = 8;   // covers PAYLOAD_LEN up to 255

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] seq_q, seq_d;
   logic [WIDTH-1:0] tx_data_q;
   logic             tx_valid_q;

   logic             load_ok;
   logic             load;
   logic [WIDTH-1:0] load_byte;
   logic             pop;

   // The output register can take a new byte when empty or being drained now.
   assign load_ok = !tx_valid_q || bus.tx_ready;

   // Next-state, datapath updates and the byte to load into the output register.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      seq_d     = seq_q;
      load      = 1'b0;
      load_byte = '0;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.fifo_nempty && load_ok) begin
               load      = 1'b1;
               load_byte = SYNC_BYTE;
               state_d   = SEQ;
            end
         end
         SEQ: begin
            if (load_ok) begin
               load      = 1'b1;
               load_byte = seq_q;
               acc_d     = seq_q;
               cnt_d     = '0;
               state_d   = PAYLOAD;
            end
         end
         PAYLOAD: begin
            pop = bus.fifo_nempty && load_ok;
            if (pop) begin
               load      = 1'b1;
               load_byte = bus.fifo_data;
               acc_d     = acc_q + bus.fifo_data;
               cnt_d     = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(PAYLOAD_LEN - 1)) begin
                  state_d = CHK;
               end
            end
         end
         CHK: begin
            if (load_ok) begin
               load      = 1'b1;
               load_byte = (~acc_q) + WIDTH'(1);
               seq_d     = seq_q + WIDTH'(1);
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, checksum/counter/sequence registers and the tx output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         seq_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         seq_q   <= seq_d;
         if (load) begin
            tx_data_q  <= load_byte;
            tx_valid_q <= 1'b1;
         end else if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
         end
      end
   end

   assign bus.fifo_pop = pop;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.seq      = seq_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_fifo_packet_framer.sv
// Testbench for fifo_packet_framer with PAYLOAD_LEN=4: a queue-based FIFO
// model feeds the DUT, a frame-level reference model fills the expected byte
// queue as bytes are offered, and a monitor checks every accepted tx byte.
module tb_fifo_packet_framer;
   import fifo_packet_framer_pkg::*;

   localparam int W  = 8;
   localparam int PL = 4;
   localparam int FL = PL + 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fifo_packet_framer_if #(.WIDTH(W)) bus ();

   fifo_packet_framer #(
      .WIDTH      (W),
      .PAYLOAD_LEN(PL),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] log_q[$];
   int           cyc_q[$];
   int           n_checks  = 0;
   int           n_fail    = 0;
   int           ready_pct = 100;
   int           cycle     = 0;
   int           frame_pos = 0;
   int           m_seq     = 0;
   int           m_cnt     = 0;
   int           m_sum     = 0;

   logic [W-1:0] f12_tbl[14] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6,
                                 8'hA5, 8'h01, 8'h05, 8'h06, 8'h07, 8'h08, 8'hE5};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Frame-level reference: every PL offered bytes become SYNC, seq, payload, chk.
   task automatic model_push(input logic [W-1:0] b);
      if (m_cnt == 0) begin
         exp_q.push_back(8'hA5);
         exp_q.push_back(W'(m_seq));
         m_sum = m_seq;
      end
      exp_q.push_back(b);
      m_sum += int'(b);
      m_cnt++;
      if (m_cnt == PL) begin
         exp_q.push_back(W'(((1 << W) - (m_sum % (1 << W))) % (1 << W)));
         m_seq = (m_seq + 1) % (1 << W);
         m_cnt = 0;
      end
   endtask

   task automatic push_byte(input logic [W-1:0] b);
      fifo_q.push_back(b);
      model_push(b);
   endtask

   task automatic wait_idle(input string name, input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && fifo_q.size() == 0 && !bus.tx_valid && !bus.busy) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, %0d bytes still expected", name, max_cycles, exp_q.size());
   endtask

   // FIFO model and tx_ready driver: inputs change 1 time unit after each edge.
   initial begin : drv
      logic pop_s;
      logic [W-1:0] dummy;
      bus.fifo_nempty = 1'b0;
      bus.fifo_data   = '0;
      bus.tx_ready    = 1'b1;
      forever begin
         @(negedge clk);
         pop_s = bus.fifo_pop;
         @(posedge clk);
         cycle++;
         #1;
         if (pop_s && fifo_q.size() > 0) dummy = fifo_q.pop_front();
         bus.fifo_nempty = (fifo_q.size() > 0);
         bus.fifo_data   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
         bus.tx_ready    = ($urandom_range(0, 99) < ready_pct);
      end
   end

   // Monitor: protocol checks and scoreboard compare on every accepted byte.
   initial begin : mon
      logic pv, pr;
      logic [W-1:0] pd, e;
      pv = 1'b0; pr = 1'b0; pd = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            frame_pos = 0;
            pv = 1'b0;
            continue;
         end
         if (pv && !pr) begin
            check("stall_valid_held", bus.tx_valid, 1);
            check("stall_data_held", bus.tx_data, pd);
         end
         if (bus.fifo_pop) begin
            check("pop_only_nonempty", bus.fifo_nempty, 1);
            check("pop_only_load_ok", !(bus.tx_valid && !bus.tx_ready), 1);
         end
         if (bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_byte: got %0h with no byte expected", bus.tx_data);
            end else begin
               e = exp_q.pop_front();
               check("tx_byte", bus.tx_data, e);
            end
            log_q.push_back(bus.tx_data);
            cyc_q.push_back(cycle);
            frame_pos = (frame_pos + 1) % FL;
         end
         pv = bus.tx_valid; pr = bus.tx_ready; pd = bus.tx_data;
      end
   end

   initial begin : main
      logic [W-1:0] tmp[$];
      int rst_idx;
      bit hit;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", bus.tx_valid, 0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_fifo_pop", bus.fifo_pop, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_seq", bus.seq, 0);
      @(posedge clk); #2; rst_n = 1'b1;

      // Frames 1 and 2 with known contents
      @(posedge clk); #2;
      for (int i = 1; i <= 4; i++) push_byte(W'(i));
      wait_idle("frame1", 100);
      check("f1_busy", bus.busy, 0);
      check("f1_seq", bus.seq, 1);
      @(posedge clk); #2;
      for (int i = 5; i <= 8; i++) push_byte(W'(i));
      wait_idle("frame2", 100);
      check("f2_seq", bus.seq, 2);
      check("f12_len", log_q.size(), 14);
      for (int i = 0; i < 14 && i < log_q.size(); i++) check("f12_byte", log_q[i], f12_tbl[i]);
      for (int i = 1; i < FL && i < cyc_q.size(); i++) check("f1_back_to_back", cyc_q[i] - cyc_q[0], i);

      // Backpressure with random tx_ready (30% high)
      ready_pct = 30;
      @(posedge clk); #2;
      for (int i = 0; i < 6 * PL; i++) push_byte(W'($urandom_range(0, 255)));
      wait_idle("backpressure", 3000);
      ready_pct = 100;

      // Starvation mid-payload
      @(posedge clk); #2;
      push_byte(W'($urandom_range(0, 255)));
      push_byte(W'($urandom_range(0, 255)));
      repeat (8) @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("gap_tx_valid", bus.tx_valid, 0);
         check("gap_fifo_pop", bus.fifo_pop, 0);
      end
      check("gap_busy", bus.busy, 1);
      @(posedge clk); #2;
      push_byte(W'($urandom_range(0, 255)));
      push_byte(W'($urandom_range(0, 255)));
      wait_idle("starvation", 100);

      // Sequence wrap: 257 frames of zero payload
      @(posedge clk); #2;
      for (int i = 0; i < 257 * PL; i++) push_byte('0);
      wait_idle("seq_wrap", 5000);
      check("wrap_seq", bus.seq, m_seq);

      // Reset after the third byte of a frame
      @(posedge clk); #2;
      for (int i = 0; i < 2 * PL; i++) push_byte(W'($urandom_range(1, 255)));
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(posedge clk);
         if (frame_pos == 3) hit = 1'b1;
      end
      check("reset_point_reached", hit, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_tx_valid", bus.tx_valid, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_seq", bus.seq, 0);
      check("midrst_fifo_pop", bus.fifo_pop, 0);
      rst_idx = log_q.size();
      exp_q.delete();
      m_seq = 0;
      m_cnt = 0;
      tmp = fifo_q;
      foreach (tmp[i]) model_push(tmp[i]);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      while (m_cnt != 0) push_byte(W'($urandom_range(0, 255)));
      wait_idle("after_reset", 200);
      if (log_q.size() > rst_idx + 1) begin
         check("post_rst_sync", log_q[rst_idx], 8'hA5);
         check("post_rst_seq", log_q[rst_idx + 1], 0);
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL post_rst_frame: got %0d bytes after reset, required at least 2", log_q.size() - rst_idx);
      end
      check("exp_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_packet_framer.md
Name: fifo_packet_framer

Overview:
- Consumer stage directly downstream of the cross-clock FIFO read port, in the FIFO's read-clock domain.
- Pops sample bytes from the FIFO and wraps every PAYLOAD_LEN bytes into a frame: sync byte, sequence number, payload, checksum.
- Presents frames as a valid/ready byte stream to the host-link transmitter (UART/USB serializer).

Parameters:
- WIDTH, 8: byte width of FIFO data and tx stream. Checksum and sequence are also WIDTH bits.
- PAYLOAD_LEN, 16: payload bytes per frame. Legal range is 1..255.
- SYNC_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  in  1  single clock; the FIFO read clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fifo_nempty  in  1  FIFO holds at least one word. fifo_data is valid while this is high (first-word-fall-through).
- fifo_data  in  WIDTH  head word of the FIFO.
- fifo_pop  out  1  consume the head word this cycle. Never asserted while fifo_nempty=0.
- tx_data  out  WIDTH  frame byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts tx_data this cycle.
- busy  out  1  a frame is in progress (state != IDLE).
- seq  out  WIDTH  sequence number of the current or next frame.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx_valid=0, tx_data=0, fifo_pop=0, busy=0, seq=0.
  - Checksum accumulator = 0, byte counter = 0, state = IDLE.
- Output register:
  - tx_data/tx_valid are registered.
  - Transfer occurs when tx_valid && tx_ready.
  - While tx_valid && !tx_ready, tx_data is held stable.
  - load_ok = !tx_valid || tx_ready. A new byte may enter the register only when load_ok=1.
  - Sustained throughput is 1 byte/cycle.
- State machine (states IDLE, SYNC, SEQ, PAYLOAD, CHK):
  - IDLE: when fifo_nempty && load_ok, load SYNC_BYTE and go to SEQ. A frame never starts on an empty FIFO.
  - SEQ: when load_ok, load seq, set acc=seq, cnt=0, go to PAYLOAD.
  - PAYLOAD: fifo_pop = fifo_nempty && load_ok (combinational). On pop, load fifo_data, acc += fifo_data, cnt += 1. After the PAYLOAD_LEN-th pop, go to CHK.
  - CHK: when load_ok, load (~acc + 1) mod 2^WIDTH, seq += 1, go to IDLE.
  - SYNC state: reserved encoding, unreachable. Any illegal state returns to IDLE.
- Frame definition:
  - Frame length is PAYLOAD_LEN+3 bytes.
  - Checksum rule: (seq + sum(payload) + chk) mod 2^WIDTH == 0. SYNC_BYTE is excluded from the sum.
- Latency: an IDLE→SYNC decision in cycle N gives tx_valid=1 in cycle N+1. A FIFO word popped in cycle N appears on tx_data in cycle N+1.
- Boundary conditions:
  - FIFO empty mid-payload: stall with tx_valid=0 once the last byte is accepted. No padding, no timeout.
  - Simultaneous tx_ready and pop: the new byte replaces the accepted byte with no bubble.
  - seq wraps 255→0 (WIDTH=8) without any flag.
  - Reset mid-frame: the partial frame is abandoned and bytes already popped are lost. After reset, the next frame starts with SYNC and seq=0.
  - tx_ready low in IDLE: no effect, because no byte is pending.

Decomposition:
- Shared package/include holds the state encoding localparams (IDLE=0, SYNC=1, SEQ=2, PAYLOAD=3, CHK=4) and the default SYNC_BYTE constant, both shared with the host-side decoder model.
- No sub-module. The checksum accumulator and byte counter are inline. Target is roughly 150 lines of RTL.

Test Plan:
- PAYLOAD_LEN=4, FIFO preloaded 01,02,03,04, tx_ready=1 → tx stream A5,00,01,02,03,04,F6 on 7 consecutive cycles; busy then 0; seq=1.
- Second frame with 05,06,07,08 → A5,01,05,06,07,08,E5; seq=2.
- Backpressure: tx_ready toggled 1/0 randomly (30% high) → identical byte sequence; tx_data stable while stalled; no pop while tx_valid && !tx_ready.
- Starvation: FIFO supplies 2 bytes, then 0 for 20 cycles, then 2 more → tx_valid low and fifo_pop never high during the gap; frame completes with the correct checksum.
- Sequence wrap: run 257 frames of zeros → seq bytes 00..FF,00; checksum = (~seq+1).
- Reset: assert rst_n=0 after byte 3 of a frame → tx_valid=0 in the same cycle; after release, the next frame is A5,00,… using the remaining FIFO data; checksum correct.
